// File: rtl/mmio_int_ctrl_if.sv
// Register-port and interrupt handshake bundle for mmio_int_ctrl.
// master = CPU side, slave = controller side.
interface mmio_int_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] w_data;
  logic              w_en;
  logic [DATA_W-1:0] r_data;
  logic              hit;
  logic              int_req;
  logic [DATA_W-1:0] int_vec;
  logic              int_ack;

  modport master (
    output addr, w_data, w_en, int_ack,
    input  r_data, hit, int_req, int_vec
  );

  modport slave (
    input  addr, w_data, w_en, int_ack,
    output r_data, hit, int_req, int_vec
  );
endinterface

// File: rtl/mmio_int_ctrl.sv
// Memory-mapped prioritised interrupt controller.
// Ports: wb_clk_i, wb_rst_i, bus (addr/w_data/w_en/r_data/hit/int_*), src_i.
module mmio_int_ctrl #(
  parameter int                 N_SRC     = 4,
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 8'd232,
  parameter logic [N_SRC-1:0]   EDGE_MASK = 4'hF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  mmio_int_ctrl_if.slave   bus,
  input  logic [N_SRC-1:0] src_i
);
  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    id, id_n, winner;
  logic [N_SRC-1:0]  enable, pend_q, pending;
  logic [N_SRC-1:0]  s1, s2, hist, rise;
  logic [N_SRC-1:0]  eligible, w1c, ack_clr;
  logic              gie, eoi, we;
  logic [ADDR_W-1:0] off;
  logic [DATA_W-1:0] vec [N_SRC];
  logic [DATA_W-1:0] int_vec_q, status;

  assign off = bus.addr - BASE_ADDR;
  assign bus.hit = (bus.addr >= BASE_ADDR) &&
                   (off < ADDR_W'(4 + N_SRC));
  assign we  = bus.w_en & bus.hit;
  assign eoi = we && (off == ADDR_W'(2));
  assign w1c = (we && off == ADDR_W'(1)) ?
               bus.w_data[N_SRC-1:0] : '0;

  // Level sources expose the synchronised input directly.
  assign rise     = s2 & ~hist & EDGE_MASK;
  assign pending  = (pend_q & EDGE_MASK) | (s2 & ~EDGE_MASK);
  assign eligible = pending & enable & {N_SRC{gie}};

  assign bus.int_req = (state == REQ);
  assign bus.int_vec = int_vec_q;

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = IDW'(i);
  end

  always_comb begin
    state_n = state;
    id_n    = id;
    ack_clr = '0;
    unique case (state)
      IDLE:
        if (|eligible) begin
          state_n = REQ;
          id_n    = winner;
        end
      REQ:
        if (bus.int_ack) begin
          state_n     = SERVICE;
          ack_clr[id] = 1'b1;
        end else if (!eligible[id]) begin
          state_n = IDLE;
        end
      SERVICE:
        if (eoi) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      id        <= '0;
      int_vec_q <= '0;
    end else begin
      state <= state_n;
      id    <= id_n;
      if (state == IDLE && |eligible)
        int_vec_q <= vec[winner];
    end
  end

  // A fresh edge beats a W1C or ack clear in the same cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1     <= '0;
      s2     <= '0;
      hist   <= '0;
      pend_q <= '0;
    end else begin
      s1     <= src_i;
      s2     <= s1;
      hist   <= s2;
      pend_q <= ((pend_q & ~w1c & ~ack_clr) | rise)
                & EDGE_MASK;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      enable <= '0;
      gie    <= 1'b0;
      for (int i = 0; i < N_SRC; i++) vec[i] <= '0;
    end else if (we) begin
      if (off == ADDR_W'(0))
        enable <= bus.w_data[N_SRC-1:0];
      if (off == ADDR_W'(3))
        gie <= bus.w_data[0];
      for (int i = 0; i < N_SRC; i++)
        if (off == ADDR_W'(4 + i)) vec[i] <= bus.w_data;
    end
  end

  always_comb begin
    status           = '0;
    status[DATA_W-1] = gie;
    status[DATA_W-2] = (state == SERVICE);
    status[IDW-1:0]  = id;
  end

  always_comb begin
    bus.r_data = '0;
    if (bus.hit) begin
      if (off == ADDR_W'(0))
        bus.r_data[N_SRC-1:0] = enable;
      if (off == ADDR_W'(1))
        bus.r_data[N_SRC-1:0] = pending;
      if (off == ADDR_W'(2))
        bus.r_data = status;
      if (off == ADDR_W'(3))
        bus.r_data[0] = gie;
      for (int i = 0; i < N_SRC; i++)
        if (off == ADDR_W'(4 + i)) bus.r_data = vec[i];
    end
  end
endmodule

// File: tb/tb_mmio_int_ctrl.sv
// Directed bench for mmio_int_ctrl: register table plus
// interrupt sequences on an edge-mode and a level-mode instance.
module tb_mmio_int_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] src_e = '0;
  logic [3:0] src_l = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_int_ctrl_if #(.ADDR_W(8), .DATA_W(8)) be ();
  mmio_int_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bl ();

  mmio_int_ctrl #(.EDGE_MASK(4'hF)) dut_e (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(be), .src_i(src_e)
  );
  mmio_int_ctrl #(.EDGE_MASK(4'h0)) dut_l (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bl), .src_i(src_l)
  );

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic       exp_hit;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input bit l, input logic [7:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    if (l) begin
      bl.addr = a; bl.w_data = d; bl.w_en = 1'b1;
    end else begin
      be.addr = a; be.w_data = d; be.w_en = 1'b1;
    end
    @(negedge clk);
    bl.w_en = 1'b0;
    be.w_en = 1'b0;
  endtask

  task automatic rd(input bit l, input logic [7:0] a,
                    input logic [7:0] m, input logic [7:0] e,
                    input string nm);
    logic [7:0] r;
    if (l) bl.addr = a; else be.addr = a;
    #1;
    r = l ? bl.r_data : be.r_data;
    chk(nm, r & m, e);
  endtask

  function automatic logic req(input bit l);
    return l ? bl.int_req : be.int_req;
  endfunction

  function automatic logic [7:0] ivec(input bit l);
    return l ? bl.int_vec : be.int_vec;
  endfunction

  task automatic ack(input bit l);
    @(negedge clk);
    if (l) bl.int_ack = 1'b1; else be.int_ack = 1'b1;
    @(negedge clk);
    bl.int_ack = 1'b0;
    be.int_ack = 1'b0;
  endtask

  task automatic wait_req(input bit l, input string nm);
    int n;
    n = 0;
    while (!req(l) && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(nm, req(l), 1);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'd232, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 8'd232, 8'hFF, 8'h0F, 1'b1};
    tbl[2]  = '{1'b1, 8'd235, 8'hFF, 8'h01, 1'b1};
    tbl[3]  = '{1'b1, 8'd236, 8'hA5, 8'hA5, 1'b1};
    tbl[4]  = '{1'b1, 8'd239, 8'h3C, 8'h3C, 1'b1};
    tbl[5]  = '{1'b1, 8'd240, 8'h55, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'd239, 8'h00, 8'h3C, 1'b1};
    tbl[7]  = '{1'b1, 8'd231, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'd232, 8'h00, 8'h0F, 1'b1};
    tbl[9]  = '{1'b0, 8'd233, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 8'd234, 8'h00, 8'h80, 1'b1};
    tbl[11] = '{1'b1, 8'd237, 8'h11, 8'h11, 1'b1};
    tbl[12] = '{1'b1, 8'd235, 8'h00, 8'h00, 1'b1};
    tbl[13] = '{1'b1, 8'd232, 8'h00, 8'h00, 1'b1};

    be.addr = '0; be.w_data = '0; be.w_en = 1'b0; be.int_ack = 1'b0;
    bl.addr = '0; bl.w_data = '0; bl.w_en = 1'b0; bl.int_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_int_req", be.int_req, 0);
    chk("reset_int_vec", be.int_vec, 0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) wr(0, tbl[i].a, tbl[i].d);
      rd(0, tbl[i].a, 8'hFF, tbl[i].exp, $sformatf("tbl%0d_rdata", i));
      chk($sformatf("tbl%0d_hit", i), be.hit, tbl[i].exp_hit);
    end

    // single edge source
    wr(0, 8'd238, 8'h40);
    wr(0, 8'd232, 8'h04);
    wr(0, 8'd235, 8'h01);
    @(negedge clk);
    src_e[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("edge_req_early", be.int_req, 0);
    rd(0, 8'd233, 8'hFF, 8'h04, "edge_pending_set");
    @(negedge clk);
    chk("edge_req_lat", be.int_req, 1);
    chk("edge_vec", be.int_vec, 8'h40);
    src_e[2] = 1'b0;
    ack(0);
    chk("edge_ack_req", be.int_req, 0);
    rd(0, 8'd233, 8'hFF, 8'h00, "edge_ack_pend");
    @(negedge clk);
    rd(0, 8'd234, 8'h40, 8'h40, "edge_in_service");
    wr(0, 8'd234, 8'h00);
    rd(0, 8'd234, 8'h40, 8'h00, "edge_eoi");

    // priority
    wr(0, 8'd232, 8'h0F);
    @(negedge clk);
    src_e[3] = 1'b1;
    src_e[1] = 1'b1;
    wait_req(0, "prio_req1");
    chk("prio_vec1", be.int_vec, 8'h11);
    rd(0, 8'd234, 8'h03, 8'h01, "prio_id1");
    src_e = '0;
    ack(0);
    wr(0, 8'd234, 8'h00);
    chk("prio_idle_gap", be.int_req, 0);
    wait_req(0, "prio_req2");
    chk("prio_vec2", be.int_vec, 8'h3C);
    ack(0);
    wr(0, 8'd234, 8'h00);

    // masking while in REQ
    wr(0, 8'd232, 8'h01);
    @(negedge clk);
    src_e[0] = 1'b1;
    wait_req(0, "mask_req");
    src_e[0] = 1'b0;
    wr(0, 8'd232, 8'h00);
    @(negedge clk);
    chk("mask_drop", be.int_req, 0);
    rd(0, 8'd233, 8'hFF, 8'h01, "mask_pend_kept");
    wr(0, 8'd232, 8'h01);
    wait_req(0, "mask_return");
    chk("mask_vec", be.int_vec, 8'hA5);
    ack(0);
    wr(0, 8'd234, 8'h00);

    // W1C vs new edge collision
    wr(0, 8'd232, 8'h00);
    @(negedge clk);
    src_e[1] = 1'b1;
    repeat (2) @(negedge clk);
    src_e[1] = 1'b0;
    repeat (4) @(negedge clk);
    rd(0, 8'd233, 8'hFF, 8'h02, "coll_pre_pend");
    wr(0, 8'd233, 8'h02);
    rd(0, 8'd233, 8'hFF, 8'h00, "w1c_alone");
    @(negedge clk);
    src_e[1] = 1'b1;
    @(negedge clk);
    wr(0, 8'd233, 8'h02);
    rd(0, 8'd233, 8'hFF, 8'h02, "coll_pend");
    src_e[1] = 1'b0;

    // reset mid-REQ
    wr(0, 8'd232, 8'h02);
    wait_req(0, "rst_pre_req");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_int_req", be.int_req, 0);
    chk("rst_int_vec", be.int_vec, 0);
    for (int a = 232; a < 240; a++) begin
      @(negedge clk);
      rd(0, 8'(a), 8'hFF, 8'h00, $sformatf("rst_reg%0d", a));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", be.int_req, 0);
    rd(0, 8'd234, 8'hFF, 8'h00, "rst_status");

    // level source
    wr(1, 8'd236, 8'h77);
    wr(1, 8'd232, 8'h01);
    wr(1, 8'd235, 8'h01);
    @(negedge clk);
    src_l[0] = 1'b1;
    wait_req(1, "lvl_req");
    chk("lvl_vec", bl.int_vec, 8'h77);
    wr(1, 8'd233, 8'h01);
    rd(1, 8'd233, 8'hFF, 8'h01, "lvl_w1c_ignored");
    chk("lvl_w1c_req", bl.int_req, 1);
    ack(1);
    chk("lvl_ack", bl.int_req, 0);
    wr(1, 8'd234, 8'h00);
    wait_req(1, "lvl_rereq");
    src_l[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("lvl_drop_req", bl.int_req, 0);
    rd(1, 8'd233, 8'hFF, 8'h00, "lvl_drop_pend");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
